// File: rtl/exe_hazard_ctrl.sv
// Hazard control for the decode/execute register: operand forwarding selects,
// load-use stall and taken-jump flush sequencing, with saturating event counters.
module exe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int LU_CYCLES    = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_dec,
  input  logic [3:0]       rp_dec,
  input  logic [3:0]       rs_dec,
  input  logic             use_rp_dec,
  input  logic             use_rs_dec,
  input  logic             valid_exe,
  input  logic [3:0]       rg_exe,
  input  logic             we_reg_exe,
  input  logic             load_exe,
  input  logic             valid_mem,
  input  logic [3:0]       rg_mem,
  input  logic             we_reg_mem,
  input  logic             salto_taken,
  output logic             stall_pc,
  output logic             stall_dec,
  output logic             flush_dec,
  output logic             prohib,
  output logic [1:0]       selOp_A,
  output logic [1:0]       selOp_B,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_LU    = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  localparam logic [3:0] FL_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] LU_LOAD = 4'(LU_CYCLES - 1);
  // A single-cycle sequence is fully covered by the detecting cycle, so stay in RUN.
  localparam logic [1:0] JMP_ST  = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
  localparam logic [1:0] LU_ST   = (LU_CYCLES > 1) ? ST_LU : ST_RUN;

  logic       hit_e_rp, hit_e_rs, hit_m_rp, hit_m_rs, lu;
  logic [1:0] state_nxt;
  logic [3:0] dcnt, dcnt_nxt;

  assign hit_e_rp = valid_exe & we_reg_exe & use_rp_dec & (rg_exe == rp_dec);
  assign hit_e_rs = valid_exe & we_reg_exe & use_rs_dec & (rg_exe == rs_dec);
  assign hit_m_rp = valid_mem & we_reg_mem & use_rp_dec & (rg_mem == rp_dec);
  assign hit_m_rs = valid_mem & we_reg_mem & use_rs_dec & (rg_mem == rs_dec);
  assign lu       = valid_dec & load_exe & (hit_e_rp | hit_e_rs);

  always_comb begin
    stall_pc  = 1'b0;
    stall_dec = 1'b0;
    flush_dec = 1'b0;
    prohib    = 1'b0;
    selOp_A   = 2'b00;
    selOp_B   = 2'b00;
    state_nxt = state;
    dcnt_nxt  = dcnt;
    case (state)
      ST_RUN: begin
        if (valid_dec) begin
          if (hit_e_rp && !load_exe) selOp_A = 2'b01;
          else if (hit_m_rp)         selOp_A = 2'b10;
          if (hit_e_rs && !load_exe) selOp_B = 2'b01;
          else if (hit_m_rs)         selOp_B = 2'b10;
        end
        if (salto_taken) begin
          flush_dec = 1'b1;
          prohib    = 1'b1;
          state_nxt = JMP_ST;
          dcnt_nxt  = FL_LOAD;
        end else if (lu) begin
          stall_pc  = 1'b1;
          stall_dec = 1'b1;
          prohib    = 1'b1;
          state_nxt = LU_ST;
          dcnt_nxt  = LU_LOAD;
        end
      end
      ST_LU: begin
        if (salto_taken) begin
          flush_dec = 1'b1;
          prohib    = 1'b1;
          state_nxt = JMP_ST;
          dcnt_nxt  = FL_LOAD;
        end else begin
          stall_pc  = 1'b1;
          stall_dec = 1'b1;
          prohib    = 1'b1;
          dcnt_nxt  = dcnt - 4'd1;
          if (dcnt <= 4'd1) state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_dec = 1'b1;
        prohib    = 1'b1;
        if (salto_taken) begin
          state_nxt = JMP_ST;
          dcnt_nxt  = FL_LOAD;
        end else begin
          dcnt_nxt = dcnt - 4'd1;
          if (dcnt <= 4'd1) state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        dcnt_nxt  = '0;
      end
    endcase
    if (rst) begin
      stall_pc  = 1'b0;
      stall_dec = 1'b0;
      flush_dec = 1'b0;
      prohib    = 1'b0;
      selOp_A   = 2'b00;
      selOp_B   = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      dcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
      if (stall_dec && !flush_dec && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_dec && flush_cnt != '1)               flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl: two instances (LU=1/16-bit counters and
// LU=3/2-bit counters) share one stimulus stream.
module tb_exe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_dec, use_rp_dec, use_rs_dec;
  logic [3:0] rp_dec, rs_dec, rg_exe, rg_mem;
  logic       valid_exe, we_reg_exe, load_exe, valid_mem, we_reg_mem, salto_taken;

  logic        a_stall_pc, a_stall_dec, a_flush_dec, a_prohib;
  logic [1:0]  a_sel_a, a_sel_b, a_state;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_stall_pc, b_stall_dec, b_flush_dec, b_prohib;
  logic [1:0]  b_sel_a, b_sel_b, b_state;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  exe_hazard_ctrl #(.FLUSH_CYCLES(2), .LU_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .valid_dec(valid_dec), .rp_dec(rp_dec), .rs_dec(rs_dec),
    .use_rp_dec(use_rp_dec), .use_rs_dec(use_rs_dec), .valid_exe(valid_exe),
    .rg_exe(rg_exe), .we_reg_exe(we_reg_exe), .load_exe(load_exe),
    .valid_mem(valid_mem), .rg_mem(rg_mem), .we_reg_mem(we_reg_mem),
    .salto_taken(salto_taken), .stall_pc(a_stall_pc), .stall_dec(a_stall_dec),
    .flush_dec(a_flush_dec), .prohib(a_prohib), .selOp_A(a_sel_a), .selOp_B(a_sel_b),
    .state(a_state), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  exe_hazard_ctrl #(.FLUSH_CYCLES(2), .LU_CYCLES(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .valid_dec(valid_dec), .rp_dec(rp_dec), .rs_dec(rs_dec),
    .use_rp_dec(use_rp_dec), .use_rs_dec(use_rs_dec), .valid_exe(valid_exe),
    .rg_exe(rg_exe), .we_reg_exe(we_reg_exe), .load_exe(load_exe),
    .valid_mem(valid_mem), .rg_mem(rg_mem), .we_reg_mem(we_reg_mem),
    .salto_taken(salto_taken), .stall_pc(b_stall_pc), .stall_dec(b_stall_dec),
    .flush_dec(b_flush_dec), .prohib(b_prohib), .selOp_A(b_sel_a), .selOp_B(b_sel_b),
    .state(b_state), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  // ctrl packs are {stall_pc, stall_dec, flush_dec, prohib}
  wire [3:0] a_ctrl = {a_stall_pc, a_stall_dec, a_flush_dec, a_prohib};
  wire [3:0] b_ctrl = {b_stall_pc, b_stall_dec, b_flush_dec, b_prohib};
  wire [7:0] a_all  = {a_ctrl, a_sel_a, a_sel_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu_inputs();
    valid_dec = 1'b1; rp_dec = 4'd0; use_rp_dec = 1'b0; rs_dec = 4'd5; use_rs_dec = 1'b1;
    valid_exe = 1'b1; rg_exe = 4'd5; we_reg_exe = 1'b1; load_exe = 1'b1;
    valid_mem = 1'b0; rg_mem = 4'd0; we_reg_mem = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; salto_taken = 1'b1;
    valid_dec = 1'b0; rp_dec = '0; rs_dec = '0; use_rp_dec = 1'b0; use_rs_dec = 1'b0;
    valid_exe = 1'b0; rg_exe = '0; we_reg_exe = 1'b0; load_exe = 1'b0;
    valid_mem = 1'b0; rg_mem = '0; we_reg_mem = 1'b0;

    // reset held with a jump pending
    step();
    check("rst1_out", a_all, 8'h00);
    step();
    check("rst2_out", a_all, 8'h00);
    check("rst_state", a_state, 2'b00);
    check("rst_stall_cnt", a_stall_cnt, 0);
    check("rst_flush_cnt", a_flush_cnt, 0);
    rst = 1'b0; salto_taken = 1'b0;
    #1;
    check("post_rst_out", a_all, 8'h00);

    // forwarding
    valid_dec = 1'b1; rp_dec = 4'd3; use_rp_dec = 1'b1; rs_dec = 4'd7; use_rs_dec = 1'b1;
    valid_exe = 1'b1; rg_exe = 4'd3; we_reg_exe = 1'b1; load_exe = 1'b0;
    valid_mem = 1'b1; rg_mem = 4'd3; we_reg_mem = 1'b1;
    #1;
    check("fwd_exe_a", a_sel_a, 2'b01);
    check("fwd_exe_b", a_sel_b, 2'b00);
    check("fwd_exe_ctrl", a_ctrl, 4'b0000);
    we_reg_exe = 1'b0; #1;
    check("fwd_mem_a", a_sel_a, 2'b10);
    rs_dec = 4'd3; #1;
    check("fwd_mem_b", a_sel_b, 2'b10);
    use_rp_dec = 1'b0; #1;
    check("fwd_unused_a", a_sel_a, 2'b00);

    // load-use
    step();
    set_lu_inputs(); #1;
    check("lu_a_ctrl", a_ctrl, 4'b1101);
    check("lu_b_ctrl", b_ctrl, 4'b1101);
    check("lu_sel_b", a_sel_b, 2'b00);
    step();
    valid_exe = 1'b0; #1;
    check("lu1_a_state", a_state, 2'b00);
    check("lu1_a_cnt", a_stall_cnt, 1);
    check("lu1_a_ctrl", a_ctrl, 4'b0000);
    check("lu2_b_state", b_state, 2'b01);
    check("lu2_b_ctrl", b_ctrl, 4'b1101);
    step();
    check("lu3_b_state", b_state, 2'b01);
    check("lu3_b_ctrl", b_ctrl, 4'b1101);
    step();
    check("lu_end_b_state", b_state, 2'b00);
    check("lu_end_b_ctrl", b_ctrl, 4'b0000);
    check("lu_end_b_cnt", b_stall_cnt, 3);

    // taken jump
    step();
    salto_taken = 1'b1; #1;
    check("jmp1_ctrl", a_ctrl, 4'b0011);
    check("jmp1_state", a_state, 2'b00);
    step();
    salto_taken = 1'b0; #1;
    check("jmp2_state", a_state, 2'b10);
    check("jmp2_ctrl", a_ctrl, 4'b0011);
    step();
    check("jmp_end_state", a_state, 2'b00);
    check("jmp_end_ctrl", a_ctrl, 4'b0000);
    check("jmp_flush_cnt", a_flush_cnt, 2);

    // jump and load-use together: jump wins
    step();
    set_lu_inputs(); salto_taken = 1'b1; #1;
    check("both_a_ctrl", a_ctrl, 4'b0011);
    check("both_b_ctrl", b_ctrl, 4'b0011);
    step();
    valid_exe = 1'b0; salto_taken = 1'b0; #1;
    check("both_state", a_state, 2'b10);
    check("both_stall_cnt", a_stall_cnt, 1);
    step();
    check("both_end_state", a_state, 2'b00);
    check("both_flush_cnt", a_flush_cnt, 4);
    check("both_b_stall_cnt", b_stall_cnt, 3);

    // five more load-use events; 2-bit counter must hold at 3
    for (int i = 0; i < 5; i++) begin
      step(); valid_exe = 1'b1;
      step(); valid_exe = 1'b0;
      step(); step(); step();
    end
    step();
    check("sat_a_cnt", a_stall_cnt, 6);
    check("sat_b_cnt", b_stall_cnt, 3);
    check("sat_b_state", b_state, 2'b00);

    // jump aborts an LU_STALL sequence
    step(); valid_exe = 1'b1;
    step(); valid_exe = 1'b0; salto_taken = 1'b1; #1;
    check("abort_b_state", b_state, 2'b01);
    check("abort_b_ctrl", b_ctrl, 4'b0011);
    step(); salto_taken = 1'b0; #1;
    check("abort_b_flush", b_state, 2'b10);
    step();
    check("abort_b_end", b_state, 2'b00);

    // reset in the middle of a flush
    step(); salto_taken = 1'b1;
    step(); salto_taken = 1'b0; rst = 1'b1; #1;
    check("rstf_state_before", a_state, 2'b10);
    check("rstf_out", a_all, 8'h00);
    step(); rst = 1'b0; #1;
    check("rstf_state", a_state, 2'b00);
    check("rstf_flush_dec", a_flush_dec, 1'b0);
    check("rstf_flush_cnt", a_flush_cnt, 0);
    check("rstf_stall_cnt", a_stall_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
